// File: rtl/rst_supervisor_pkg.sv
// Shared state encoding and sizing helpers for the reset supervisor.
package rst_supervisor_pkg;

  localparam logic [1:0] HOLD   = 2'd0;
  localparam logic [1:0] STABLE = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] SWRST  = 2'd3;

  typedef enum logic [1:0] {
    StHold   = HOLD,
    StStable = STABLE,
    StRun    = RUN,
    StSwRst  = SWRST
  } state_e;

  // Shared lock-stable / sw-reset counter width, never below one bit.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rst_supervisor_sync_debounce.sv
// Two-flop synchronizer followed by a restart-on-change debounce counter.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic deb_o
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          deb_q, deb_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= async_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign sync_o = s2_q;
  assign deb_o  = deb_q;

endmodule

// File: rtl/rst_supervisor.sv
// Qualifies PLL lock and board button into a single system reset, with sw reset and loss count.
module rst_supervisor
  import rst_supervisor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 64,
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned CNT_W              = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             pll_lock_i,
  input  logic             btn_rst_n_i,
  input  logic             sw_rst_req_i,
  input  logic             clr_cnt_i,
  output logic             sys_rst_o,
  output logic             locked_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned CW = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);

  logic             lock1_q, lock2_q;
  logic             btn_deb;
  logic             btn_sync_unused;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             loss_inc;
  logic             sys_rst_q;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_n_i),
    .async_i(btn_rst_n_i),
    .sync_o (btn_sync_unused),
    .deb_o  (btn_deb)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      lock1_q   <= 1'b0;
      lock2_q   <= 1'b0;
      state_q   <= StHold;
      cnt_q     <= '0;
      loss_q    <= '0;
      sys_rst_q <= 1'b1;
    end else begin
      lock1_q   <= pll_lock_i;
      lock2_q   <= lock1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      sys_rst_q <= (state_d != StRun);
    end
  end

  // Button press outranks lock loss, which outranks a sw reset request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_inc = 1'b0;
    if (!btn_deb) begin
      state_d = StHold;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          cnt_d = '0;
          if (lock2_q) state_d = StStable;
        end
        StStable: begin
          if (!lock2_q) begin
            state_d = StHold;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          cnt_d = '0;
          if (!lock2_q) begin
            state_d  = StHold;
            loss_inc = 1'b1;
          end else if (sw_rst_req_i) begin
            state_d = StSwRst;
          end
        end
        StSwRst: begin
          if (cnt_q == CW'(RST_HOLD_CYCLES - 1)) begin
            state_d = lock2_q ? StRun : StHold;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StHold;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    loss_d = loss_q;
    if (clr_cnt_i) begin
      loss_d = loss_inc ? CNT_W'(1) : '0;
    end else if (loss_inc && (loss_q != {CNT_W{1'b1}})) begin
      loss_d = loss_q + 1'b1;
    end
  end

  assign sys_rst_o  = sys_rst_q;
  assign locked_o   = lock2_q;
  assign state_o    = state_q;
  assign loss_cnt_o = loss_q;

endmodule

// File: tb/tb_rst_supervisor.sv
// Directed bench for rst_supervisor with DEBOUNCE=4, LOCK_STABLE=8, RST_HOLD=5, CNT_W=2.
module tb_rst_supervisor;

  logic       clk = 1'b0;
  logic       rst_n, pll_lock, btn_n, sw_req, clr_cnt;
  logic       sys_rst, locked;
  logic [1:0] state, loss;
  int         tests = 0;
  int         fails = 0;

  rst_supervisor #(
    .DEBOUNCE_CYCLES   (4),
    .LOCK_STABLE_CYCLES(8),
    .RST_HOLD_CYCLES   (5),
    .CNT_W             (2)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .pll_lock_i  (pll_lock),
    .btn_rst_n_i (btn_n),
    .sw_rst_req_i(sw_req),
    .clr_cnt_i   (clr_cnt),
    .sys_rst_o   (sys_rst),
    .locked_o    (locked),
    .state_o     (state),
    .loss_cnt_o  (loss)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input int exp, input int budget);
    int n = 0;
    while (int'(state) != exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(state), exp);
  endtask

  task automatic count_stable(input string tag);
    int n = 0;
    while (state == 2'd1 && n < 30) begin
      n++;
      tick();
    end
    check(tag, n, 8);
    check({tag, "_run"}, int'(state), 2);
    check({tag, "_rel"}, int'(sys_rst), 0);
  endtask

  initial begin
    int ok;
    int n;
    rst_n = 1'b0; pll_lock = 1'b1; btn_n = 1'b1; sw_req = 1'b0; clr_cnt = 1'b0;
    tick(3);
    check("rst_sys_rst", int'(sys_rst), 1);
    check("rst_locked", int'(locked), 0);
    check("rst_state", int'(state), 0);
    check("rst_loss", int'(loss), 0);

    // Power-up
    rst_n = 1'b1;
    tick();
    check("lock_sync_1", int'(locked), 0);
    tick();
    check("lock_sync_2", int'(locked), 1);
    wait_state("pwr_stable", 1, 40);
    check("pwr_stable_rst", int'(sys_rst), 1);
    count_stable("pwr_len");

    // Bounce shorter than the debounce window
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      btn_n = i[0];
      tick(2);
      if (state != 2'd2) ok = 0;
    end
    btn_n = 1'b1;
    tick(6);
    if (state != 2'd2) ok = 0;
    check("bounce_no_change", ok, 1);
    btn_n = 1'b0;
    tick(5);
    check("press_not_yet", int'(state), 2);
    wait_state("press_hold", 0, 10);
    check("press_sys_rst", int'(sys_rst), 1);
    btn_n = 1'b1;
    wait_state("press_rerun", 2, 40);

    // Lock loss counting and saturation
    for (int k = 1; k <= 4; k++) begin
      pll_lock = 1'b0;
      tick(3);
      check("loss_hold", int'(state), 0);
      check("loss_cnt", int'(loss), (k > 3) ? 3 : k);
      pll_lock = 1'b1;
      wait_state("loss_rerun", 2, 40);
    end
    // Clear coinciding with an increment leaves one
    pll_lock = 1'b0;
    tick(2);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_with_inc", int'(loss), 1);
    pll_lock = 1'b1;
    wait_state("clr_rerun", 2, 40);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_alone", int'(loss), 0);

    // Lock drop in STABLE at count 5
    pll_lock = 1'b0;
    tick(3);
    check("pre_stable_loss", int'(loss), 1);
    pll_lock = 1'b1;
    wait_state("stable_enter", 1, 10);
    tick(3);
    pll_lock = 1'b0;
    tick(2);
    check("stable_cnt5", int'(state), 1);
    tick();
    check("stable_drop_hold", int'(state), 0);
    check("stable_drop_loss", int'(loss), 1);
    pll_lock = 1'b1;
    wait_state("stable_reenter", 1, 10);
    count_stable("relock_len");

    // Software reset in RUN
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    check("swrst_state", int'(state), 3);
    n = 0;
    while (sys_rst == 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("swrst_len", n, 5);
    check("swrst_back_run", int'(state), 2);

    // Software reset ignored in HOLD
    pll_lock = 1'b0;
    tick(3);
    check("hold_for_sw", int'(state), 0);
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    tick(2);
    check("sw_in_hold", int'(state), 0);
    check("sw_in_hold_loss", int'(loss), 2);
    pll_lock = 1'b1;
    wait_state("sw_rerun", 2, 40);

    // Lock loss and sw request on the same edge
    pll_lock = 1'b0;
    tick(2);
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    check("coincide_state", int'(state), 0);
    check("coincide_loss", int'(loss), 3);
    check("coincide_rst", int'(sys_rst), 1);
    pll_lock = 1'b1;
    wait_state("coincide_rerun", 2, 40);

    // Synchronous reset during SWRST
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    tick(2);
    check("mid_swrst", int'(state), 3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_sys_rst", int'(sys_rst), 1);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_loss", int'(loss), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
